// File: rtl/gumnut_pkg.sv
// Shared widths, fetch FSM state encoding and instruction field positions
// for the gumnut instruction fetch path.
package gumnut_pkg;

  localparam int IADDR_W  = 12;
  localparam int INST_W   = 18;

  localparam int DISP_LSB = 0;
  localparam int DISP_MSB = 7;
  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/ir_reg.sv
// Instruction register: loads on ld_i when the clock enable is high,
// synchronous active-high reset to zero.
module ir_reg #(
  parameter int W = 18
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         ce_i,
  input  logic         ld_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] ir_d;
  logic [W-1:0] ir_q;

  always_comb begin
    ir_d = ir_q;
    if (ld_i) ir_d = d_i;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ir_q <= '0;
    end else if (ce_i) begin
      ir_q <= ir_d;
    end
  end

  assign q_o = ir_q;

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: one instruction-memory bus cycle per request,
// result latched into the IR. Define FETCH_TIMEOUT_EN to bound wait states.
module inst_fetch_unit #(
  parameter int IADDR_W        = 12,
  parameter int INST_W         = 18
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 15
`endif
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ClkEn_e,
  input  logic               fetch_c,
  input  logic [IADDR_W-1:0] inst_addr_i,
  output logic               inst_cyc_o,
  output logic               inst_stb_o,
  output logic [IADDR_W-1:0] inst_adr_o,
  input  logic               inst_ack_i,
  input  logic [INST_W-1:0]  inst_dat_i,
  output logic [INST_W-1:0]  instr_o,
  output logic [7:0]         disp_o,
  output logic [IADDR_W-1:0] addr_o,
  output logic               fetch_done_o,
  output logic               busy_o,
  output logic               fetch_err_o
);

  import gumnut_pkg::*;

  fetch_state_t       state_d, state_q;
  logic [IADDR_W-1:0] adr_d, adr_q;
  logic               cyc_d, cyc_q;
  logic               done_d, done_q;
  logic               busy_d, busy_q;
  logic               ir_ld;

`ifdef FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             err_d, err_q;
`endif

  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    ir_ld   = 1'b0;
`ifdef FETCH_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (fetch_c) begin
          state_d = BUS;
          adr_d   = inst_addr_i;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      BUS: begin
        // An ack on the final permitted cycle still completes normally.
        if (inst_ack_i) begin
          state_d = DONE;
          ir_ld   = 1'b1;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    cyc_d  = (state_d == BUS);
    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      cyc_q   <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else if (ClkEn_e) begin
      state_q <= state_d;
      adr_q   <= adr_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

`ifdef FETCH_TIMEOUT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else if (ClkEn_e) begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
  assign fetch_err_o = err_q;
`else
  assign fetch_err_o = 1'b0;
`endif

  ir_reg #(.W(INST_W)) u_ir (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .ce_i  (ClkEn_e),
    .ld_i  (ir_ld),
    .d_i   (inst_dat_i),
    .q_o   (instr_o)
  );

  assign inst_cyc_o   = cyc_q;
  assign inst_stb_o   = cyc_q;
  assign inst_adr_o   = adr_q;
  assign fetch_done_o = done_q;
  assign busy_o       = busy_q;
  assign disp_o       = instr_o[DISP_MSB:DISP_LSB];
  assign addr_o       = instr_o[ADDR_MSB:ADDR_LSB];

endmodule

// File: doc/inst_fetch_unit.md
# inst_fetch_unit

Instruction fetch stage sitting directly downstream of the PC unit. It takes the current instruction address, runs one instruction-memory bus cycle per fetch request, and latches the returned 18-bit word into the instruction register. It also presents the branch displacement and jump address fields back to the PC unit and a one-cycle completion pulse to the control sequencer.

## Interface
Parameters:
- IADDR_W, 12, instruction address width
- INST_W, 18, instruction word width
- TIMEOUT_CYCLES, 15, wait-state limit before abort (used only with FETCH_TIMEOUT_EN)

Ports:
- clk_i  in  1  core clock; one clock domain
- rst_i  in  1  reset, synchronous, active-high
- ClkEn_e  in  1  global clock enable; when low every register holds
- fetch_c  in  1  fetch request from control sequencer
- inst_addr_i  in  IADDR_W  address from PC unit (its inst_addr_o)
- inst_cyc_o  out  1  bus cycle valid
- inst_stb_o  out  1  bus strobe
- inst_adr_o  out  IADDR_W  registered fetch address
- inst_ack_i  in  1  bus acknowledge
- inst_dat_i  in  INST_W  read data, valid when inst_ack_i high
- instr_o  out  INST_W  instruction register contents
- disp_o  out  8  instr_o[7:0], to PC unit disp_e
- addr_o  out  IADDR_W  instr_o[11:0], to PC unit addr_e
- fetch_done_o  out  1  one-cycle pulse, new instruction valid
- busy_o  out  1  high while not IDLE
- fetch_err_o  out  1  one-cycle timeout pulse (FETCH_TIMEOUT_EN only)

## Operation
- FSM states: IDLE, BUS, DONE. All transitions qualified by ClkEn_e=1.
- IDLE: fetch_c=1 -> capture inst_addr_i into inst_adr_o, go BUS. fetch_c=0 -> stay.
- BUS: inst_cyc_o=inst_stb_o=1. inst_ack_i=1 -> load inst_dat_i into IR, go DONE. Otherwise stay (wait states unbounded unless timeout enabled).
- DONE: fetch_done_o=1, cyc/stb low, then go IDLE.
- fetch_c is ignored in BUS and DONE; no request queueing.
- inst_ack_i is ignored outside BUS.
- The IR changes only on an acknowledged BUS cycle; disp_o/addr_o are combinational slices of the IR.
- inst_adr_o is held stable for the whole BUS state even if inst_addr_i changes.
- Reset values: state IDLE, inst_cyc_o=0, inst_stb_o=0, inst_adr_o=0, instr_o=0, fetch_done_o=0, busy_o=0, fetch_err_o=0.
- Reset mid-BUS: cycle abandoned at the reset edge, IR keeps its reset value 0, and a late ack arriving in IDLE is discarded.

## Timing
- Edge N: fetch_c accepted. Cycle N+1: cyc/stb high.
- Zero-wait ack in cycle N+1 -> IR valid and fetch_done_o high in cycle N+2. Minimum fetch latency is 2 cycles; each wait state adds 1.
- Back-to-back fetches: the next accept is possible at the edge ending DONE's successor IDLE cycle, giving a 3-cycle minimum issue interval.
- ClkEn_e low stalls everything, including the timeout counter. Outputs hold and pulses stretch for the stall length.

## Configuration
- FETCH_TIMEOUT_EN defined: a counter of width $clog2(TIMEOUT_CYCLES+1) is cleared on entry to BUS and increments each enabled cycle in BUS without ack. When the count reaches TIMEOUT_CYCLES with no ack, the FSM goes to IDLE, fetch_err_o pulses for one cycle, the IR is unchanged and fetch_done_o is not asserted. An ack on the expiry cycle wins over the timeout.
- FETCH_TIMEOUT_EN undefined: no counter, fetch_err_o tied 0, BUS waits indefinitely.

## Structure
- Shared package gumnut_pkg holds IADDR_W, INST_W, the fetch_state_t enum (IDLE, BUS, DONE) and the field slice constants (DISP_LSB/MSB, ADDR_LSB/MSB).
- One sub-module, ir_reg: the IR with load enable, clock enable and synchronous reset. The FSM, address register and timeout logic stay in the top.

## Test plan
- Reset then fetch_c with inst_addr_i=12'h000 and ack in the first BUS cycle with data 18'h3_A5C3 -> instr_o=18'h3A5C3, disp_o=8'hC3, addr_o=12'h5C3, fetch_done_o pulses 2 cycles after the request.
- 3 wait states at address 12'h7FF -> inst_adr_o holds 12'h7FF throughout, fetch_done_o arrives at cycle 5.
- inst_addr_i changes and fetch_c pulses during BUS -> inst_adr_o is unchanged and no second cycle is issued.
- ClkEn_e low for 2 cycles in BUS with ack held high -> IR loads only on the first enabled edge, and fetch_done_o stretches across any stall in DONE.
- rst_i asserted mid-BUS, then an ack arrives -> cyc/stb and instr_o read 0 and the ack is ignored.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> fetch_err_o pulses, the IR is unchanged and busy_o drops. A repeat run with ack on cycle 4 -> normal completion with no error.
